dm_bus_responder: RTL and testbench

//  Data-memory responder: the memory end of the CPU load/store interface.

---
 rtl/dm_bus_responder.sv | 189 ++++++++++++++++++
 tb/tb_dm_bus_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bus_responder.sv
// Data-memory responder: serves one load or store at a time over a req/ack
// handshake with WAIT_STATES extra cycles, byte/half/word lanes and error reporting.
module dm_bus_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: the master raises req with stable wr/size/sign/addr/wdata and
    // holds them until the single-cycle ack; dropping req while waiting aborts
    // the transaction (no ack, no write). err/rdata are meaningful only with ack.

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        wr_q;
    logic        sign_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [DEPTH];

    logic          c_wr;
    logic          c_sign;
    logic [1:0]    c_size;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic          c_err;
    logic [AW-1:0] word_idx;
    logic [31:0]   cur_word;
    logic [31:0]   shifted;
    logic [31:0]   load_val;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   merged;
    logic          enter_resp;
    logic          commit;
    logic          unused_pc;

    // Live inputs in IDLE (WAIT_STATES=0 responds straight from accept), latched otherwise.
    always_comb begin
        c_wr    = wr_q;
        c_sign  = sign_q;
        c_size  = size_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        if (state == IDLE) begin
            c_wr    = wr;
            c_sign  = sign;
            c_size  = size;
            c_addr  = addr;
            c_wdata = wdata;
        end
    end

    assign c_err = (c_size == 2'b11)
                 | ((c_size == 2'b01) & c_addr[0])
                 | ((c_size == 2'b10) & (|c_addr[1:0]))
                 | (c_addr >= LIMIT);

    assign word_idx = c_addr[AW+1:2];
    assign cur_word = mem[word_idx];
    assign shifted  = cur_word >> {c_addr[1:0], 3'b000};

    always_comb begin
        load_val = shifted;
        be       = 4'b1111;
        wlanes   = c_wdata;
        case (c_size)
            2'b00: begin
                load_val = c_sign ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
                be       = 4'b0001 << c_addr[1:0];
                wlanes   = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                load_val = c_sign ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
                be       = c_addr[1] ? 4'b1100 : 4'b0011;
                wlanes   = {2{c_wdata[15:0]}};
            end
            default: begin
                load_val = shifted;
                be       = 4'b1111;
                wlanes   = c_wdata;
            end
        endcase
    end

    always_comb begin
        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wlanes[8*i +: 8];
        end
    end

    assign enter_resp = req & (((state == IDLE) & (WS == 4'd0)) |
                               ((state == WAIT) & (cnt <= 4'd1)));
    assign commit     = enter_resp & c_wr & ~c_err;
    assign unused_pc  = ^pc;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            mem[word_idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= '0;
            wr_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ack <= 1'b0;
            if (enter_resp) begin
                ack   <= 1'b1;
                err   <= c_err;
                rdata <= c_err ? 32'h0 : (c_wr ? rdata : load_val);
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        wr_q    <= wr;
                        sign_q  <= sign;
                        size_q  <= size;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= WS;
                        busy    <= 1'b1;
                        state   <= (WS == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        cnt   <= 4'd0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt <= 4'd1) begin
                        cnt   <= 4'd0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_bus_responder.sv
// Bench for dm_bus_responder: one instance with 2 wait states, one with none,
// checked against a byte-addressed reference memory through expected-response queues.
module tb_dm_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_s   [2];
    logic        wr_s    [2];
    logic        sign_s  [2];
    logic [1:0]  size_s  [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] pc_s    [2];
    logic        ack_s   [2];
    logic        err_s   [2];
    logic        busy_s  [2];
    logic [31:0] rdata_s [2];
    logic [1:0]  dbg_s   [2];

    logic [7:0]  mem_m [2][4096];
    logic [33:0] exp_q0[$];
    logic [33:0] exp_q1[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_bus_responder #(.DEPTH(1024), .WAIT_STATES(2)) u_dut_ws2 (
        .clk(clk), .reset(reset), .req(req_s[0]), .wr(wr_s[0]), .size(size_s[0]),
        .sign(sign_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]), .pc(pc_s[0]),
        .ack(ack_s[0]), .rdata(rdata_s[0]), .err(err_s[0]), .busy(busy_s[0]),
        .dbg_state(dbg_s[0]));

    dm_bus_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .reset(reset), .req(req_s[1]), .wr(wr_s[1]), .size(size_s[1]),
        .sign(sign_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]), .pc(pc_s[1]),
        .ack(ack_s[1]), .rdata(rdata_s[1]), .err(err_s[1]), .busy(busy_s[1]),
        .dbg_state(dbg_s[1]));

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory; returns {check_rdata, err, rdata}.
    function automatic logic [33:0] model_apply(input int d, input bit w, input logic [1:0] sz,
                                                input bit sg, input logic [31:0] a,
                                                input logic [31:0] wd);
        int          nbytes;
        logic [31:0] v;
        bit          bad;
        nbytes = 1 << sz;
        bad = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
              (a >= 32'd4096);
        if (bad) return {1'b1, 1'b1, 32'h0};
        if (w) begin
            for (int i = 0; i < nbytes; i++) mem_m[d][a + i] = wd[8*i +: 8];
            return {1'b0, 1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < nbytes; i++) v = v | (32'(mem_m[d][a + i]) << (8 * i));
        if (sg && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (sg && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
        return {1'b1, 1'b0, v};
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4096; i++) mem_m[d][i] = 8'h00;
    endtask

    task automatic drive(input int d, input bit w, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd);
        wr_s[d]    = w;
        size_s[d]  = sz;
        sign_s[d]  = sg;
        addr_s[d]  = a;
        wdata_s[d] = wd;
        pc_s[d]    = $urandom;
        req_s[d]   = 1'b1;
    endtask

    // Issues one transaction, waits (bounded) for ack, checks latency; leaves req high.
    task automatic txn(input int d, input bit w, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd);
        logic [33:0] e;
        int          start;
        bit          seen;
        e = model_apply(d, w, sz, sg, a, wd);
        if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        drive(d, w, sz, sg, a, wd);
        start = cyc;
        seen  = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ack_s[d]) seen = 1'b1;
        end
        if (!seen) begin
            check("ack_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(cyc - start), 32'(ws_of(d) + 1));
            check("busy_in_resp", {31'h0, busy_s[d]}, 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        req_s[d] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic count_no_ack(input int d, input int n, input string name);
        int acks;
        acks = 0;
        repeat (n) begin
            @(negedge clk);
            if (ack_s[d]) acks++;
        end
        check(name, 32'(acks), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ack pops one expected response from that instance's queue.
    task automatic mon_check(input int d, input logic [33:0] e);
        check(d == 0 ? "err_ws2" : "err_ws0", {31'h0, err_s[d]}, {31'h0, e[32]});
        if (e[33]) check(d == 0 ? "rdata_ws2" : "rdata_ws0", rdata_s[d], e[31:0]);
    endtask

    always @(negedge clk) begin
        if (ack_s[0]) begin
            if (exp_q0.size() == 0) check("unexpected_ack_ws2", 32'd1, 32'd0);
            else mon_check(0, exp_q0.pop_front());
        end
        if (ack_s[1]) begin
            if (exp_q1.size() == 0) check("unexpected_ack_ws0", 32'd1, 32'd0);
            else mon_check(1, exp_q1.pop_front());
        end
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          d;
        int          r;
        for (int i = 0; i < 2; i++) begin
            req_s[i] = 1'b0; wr_s[i] = 1'b0; sign_s[i] = 1'b0; size_s[i] = 2'b00;
            addr_s[i] = '0; wdata_s[i] = '0; pc_s[i] = '0;
        end
        clear_model();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_ack",   {31'h0, ack_s[i]},  32'd0);
            check("reset_err",   {31'h0, err_s[i]},  32'd0);
            check("reset_busy",  {31'h0, busy_s[i]}, 32'd0);
            check("reset_rdata", rdata_s[i],         32'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted mid-WAIT of a store: dropped, nothing written.
        drive(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_in_wait", {31'h0, busy_s[0]}, 32'd1);
        reset = 1'b0;
        #1;
        check("async_reset_busy", {31'h0, busy_s[0]}, 32'd0);
        req_s[0] = 1'b0;
        count_no_ack(0, 3, "ack_during_reset");
        reset = 1'b1;
        clear_model();
        count_no_ack(0, 3, "ack_after_reset");
        txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0); idle(0, 1);

        // Word store/load and lane merging.
        txn(0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h1234_5678); idle(0, 1);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);         idle(0, 1);
        txn(0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0000_00F0); idle(0, 0);
        txn(0, 1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00AB); idle(0, 0);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);         idle(0, 0);
        txn(0, 1'b0, 2'b00, 1'b1, 32'h9, 32'h0);         idle(0, 0);
        txn(0, 1'b0, 2'b00, 1'b0, 32'h9, 32'h0);         idle(0, 0);
        txn(0, 1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_8001); idle(0, 0);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);         idle(0, 0);
        txn(0, 1'b0, 2'b01, 1'b1, 32'h2, 32'h0);         idle(0, 0);

        // Error cases: misaligned, out of range, reserved size.
        txn(0, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0);         idle(0, 0);
        txn(0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'hCAFE_F00D); idle(0, 0);
        txn(0, 1'b1, 2'b11, 1'b0, 32'h4, 32'hFFFF_FFFF); idle(0, 0);
        txn(0, 1'b1, 2'b01, 1'b0, 32'h5, 32'hFFFF_FFFF); idle(0, 0);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);         idle(0, 0);

        // Abort: req dropped while waiting.
        drive(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h5555_AAAA);
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        count_no_ack(0, 6, "ack_after_abort");
        txn(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);        idle(0, 1);

        // Zero wait states, req held high: ack every 2nd cycle.
        txn(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A5_0001);
        txn(1, 1'b1, 2'b00, 1'b0, 32'h43, 32'h0000_0080);
        txn(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        txn(1, 1'b0, 2'b00, 1'b1, 32'h43, 32'h0);
        txn(1, 1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
        txn(1, 1'b0, 2'b10, 1'b0, 32'h41, 32'h0);
        idle(1, 1);

        // Random traffic over a small address window to force lane collisions.
        for (int n = 0; n < 300; n++) begin
            d = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r = $urandom_range(0, 19);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'h1000 + $urandom_range(0, 15);
            else if (r == 2) a = 32'hFFC + $urandom_range(0, 3);
            else             a = $urandom_range(0, 63);
            if ($urandom_range(0, 4) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            txn(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            idle(d, $urandom_range(0, 2));
        end

        repeat (5) @(posedge clk);
        check("queue_ws2_drained", 32'(exp_q0.size()), 32'd0);
        check("queue_ws0_drained", 32'(exp_q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
